hamle_toplayici: RTL
====================

# hamle_toplayici

Sequencing front end for the three-round game judge. Accepts one round of moves per handshake (players X and Y, two 2-bit moves each), loads them into the twelve per-round move registers that drive the judge's X11..Y23 inputs, and then samples the judge's combinational majority output `O`. It publishes a one-cycle result strobe and keeps running win/game counters. It sits directly upstream of the judge and consumes its output.

## Interface
- `SKOR_W`, default 4: width of the game and X-win counters.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `hamle_valid` input 1: the round moves on `x1/x2/y1/y2` are valid.
- `hamle_ready` output 1: the block accepts a round this cycle.
- `x1`, `x2`, `y1`, `y2` input 2 each: moves for one round (player X: x1,x2; player Y: y1,y2).
- `X11`, `X12`, `X13` output 2 each: player X first move for rounds 1/2/3, to the judge.
- `X21`, `X22`, `X23` output 2 each: player X second move for rounds 1/2/3.
- `Y11`, `Y12`, `Y13` output 2 each: player Y first move for rounds 1/2/3.
- `Y21`, `Y22`, `Y23` output 2 each: player Y second move for rounds 1/2/3.
- `O_in` input 1: the judge's majority output (1 = X won the game).
- `tur_no` output 2: index of the next round to be accepted (0..2).
- `karar` output 1: high during the evaluation cycle; all twelve move outputs belong to one game.
- `sonuc_valid` output 1: one-cycle result strobe.
- `sonuc` output 1: registered game result; it holds until the next strobe.
- `skor_x` output SKOR_W: number of games X won, modulo 2^SKOR_W.
- `oyun_sayisi` output SKOR_W: number of games completed, modulo 2^SKOR_W.

## Operation
- The FSM has two states:
  - TOPLA (collect): `hamle_ready=1`.
  - KARAR (decide): `hamle_ready=0`, `karar=1`.
- In TOPLA, a round is accepted when `hamle_valid & hamle_ready` is true at a rising edge.
  - The accepted `x1,x2,y1,y2` are written into the round-`tur_no` registers: tur_no 0 goes to X11/X21/Y11/Y21, 1 to X12/X22/Y12/Y22, and 2 to X13/X23/Y13/Y23.
  - `tur_no` increments on acceptance.
  - On the acceptance with tur_no=2, the FSM goes to KARAR and `tur_no` returns to 0.
- KARAR lasts exactly one cycle. At its closing edge:
  - `sonuc<=O_in` and `sonuc_valid<=1`.
  - `oyun_sayisi` increments, and `skor_x` increments if `O_in=1`.
  - The FSM returns to TOPLA.
- `sonuc_valid` is high for exactly one cycle: the first TOPLA cycle after KARAR.
- `O_in` is ignored in every cycle except KARAR.
- Move codes are not validated; 2'b11 passes through unchanged.
- Move registers are not cleared between games. A register is overwritten only when its round is accepted.
- Counters wrap from 2^SKOR_W-1 to 0 with no saturation and no flag.
- Reset (highest priority, any state including mid-collection): state=TOPLA; `tur_no`, all move registers, `sonuc`, `sonuc_valid`, `skor_x`, `oyun_sayisi` and `karar` are all 0. `hamle_ready` is 1 in the first cycle after reset deasserts.
- A handshake in the same cycle as `rst=1` is discarded.

## Timing
- Round acceptance: the move registers and `tur_no` update at the accepting edge.
- Third acceptance at edge k:
  - Cycle k..k+1 is KARAR, and `O_in` is sampled at edge k+1.
  - `sonuc_valid` is high during cycle k+1..k+2.
  - The first new round can be accepted at edge k+2.
- Best-case throughput: 4 cycles per game with `hamle_valid` held high.
- The judge path `X*/Y*` -> `O_in` is combinational and must settle within one clock period. The move registers are stable throughout KARAR.
- There is no combinational path from any input to any output. `hamle_ready` is a decode of the registered state.

## Structure
- Shared package holds:
  - the FSM state encoding (TOPLA, KARAR);
  - the move-width constant (2);
  - the round-count constant (3).
- A single sub-module, `tur_kaydi`, is natural: one round's four 2-bit registers with a write enable. Instantiate it three times, with enables decoded from `tur_no`.
- The judge is not instantiated here; `O_in` is wired at the parent.

## Test plan
- Reset, then idle: all move outputs 0, `tur_no=0`, `hamle_ready=1`, `sonuc_valid=0`, counters 0.
- Three rounds back-to-back with valid held high, (x1,x2,y1,y2)=(1,2,0,3),(2,2,1,1),(0,1,3,2), and `O_in=1` in KARAR:
  - X11=1, X21=2, Y11=0, Y21=3, X12=2, X22=2, Y12=1, Y22=1, X13=0, X23=1, Y13=3, Y23=2;
  - ready is low exactly one cycle;
  - one `sonuc_valid` pulse with `sonuc=1`, `skor_x=1`, `oyun_sayisi=1`.
- Valid with gaps (valid=0 for 3 cycles between rounds), and `O_in` toggled every cycle while in TOPLA:
  - no extra acceptance;
  - the result equals `O_in` in the KARAR cycle only.
- Reset asserted after two accepted rounds, while also presenting a third round: `tur_no=0`, all move registers 0, no `sonuc_valid`, counters 0.
- 16 games with `SKOR_W=4` and `O_in=1` each time: `skor_x` and `oyun_sayisi` read 15 after game 15 and 0 after game 16.
- Second game overwriting only round 1, then stalled: X11/X21/Y11/Y21 show new values, and round-2/3 registers keep the previous game's values.

Source files
------------

// File: rtl/hamle_toplayici_pkg.sv
// hamle_toplayici_pkg
// Shared definitions for the game-judge front end: the collector FSM
// state encoding, the width of one move code and the number of rounds
// that make up one game.
package hamle_toplayici_pkg;

    localparam int HAMLE_W    = 2;
    localparam int TUR_SAYISI = 3;

    typedef enum logic {
        TOPLA = 1'b0,
        KARAR = 1'b1
    } durum_t;

endpackage

// File: rtl/tur_kaydi.sv
// tur_kaydi
// Holds the four moves of one round (X first/second, Y first/second).
// The moves are loaded only when 'yaz' is high, so a round keeps its
// values across games until that same round is accepted again.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   yaz                  write enable for this round
//   x1, x2, y1, y2       incoming moves
//   x1_q, x2_q, y1_q, y2_q  stored moves, driven to the judge
import hamle_toplayici_pkg::*;

module tur_kaydi (
    input  logic               clk,
    input  logic               rst,
    input  logic               yaz,
    input  logic [HAMLE_W-1:0] x1,
    input  logic [HAMLE_W-1:0] x2,
    input  logic [HAMLE_W-1:0] y1,
    input  logic [HAMLE_W-1:0] y2,
    output logic [HAMLE_W-1:0] x1_q,
    output logic [HAMLE_W-1:0] x2_q,
    output logic [HAMLE_W-1:0] y1_q,
    output logic [HAMLE_W-1:0] y2_q
);

    // Move codes are stored as-is; 2'b11 is not filtered out.
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else if (yaz) begin
            x1_q <= x1;
            x2_q <= x2;
            y1_q <= y1;
            y2_q <= y2;
        end
    end

endmodule

// File: rtl/hamle_toplayici.sv
// hamle_toplayici
// Sequencing front end for the three-round game judge. Collects one
// round of moves per valid/ready handshake into the per-round move
// registers, then spends one cycle (KARAR) sampling the judge's
// majority output O_in, publishes it with a one-cycle strobe and keeps
// wrapping win/game counters.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   hamle_valid/ready     round handshake
//   x1, x2, y1, y2        moves of the offered round
//   X11..X23, Y11..Y23    stored moves for rounds 1..3, to the judge
//   O_in                  judge majority output (1 = X won)
//   tur_no                index of the next round to accept
//   karar                 high during the evaluation cycle
//   sonuc_valid, sonuc    result strobe and held result
//   skor_x, oyun_sayisi   X wins and games played, modulo 2^SKOR_W
import hamle_toplayici_pkg::*;

module hamle_toplayici #(
    parameter int SKOR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hamle_valid,
    output logic               hamle_ready,
    input  logic [HAMLE_W-1:0] x1,
    input  logic [HAMLE_W-1:0] x2,
    input  logic [HAMLE_W-1:0] y1,
    input  logic [HAMLE_W-1:0] y2,
    output logic [HAMLE_W-1:0] X11,
    output logic [HAMLE_W-1:0] X12,
    output logic [HAMLE_W-1:0] X13,
    output logic [HAMLE_W-1:0] X21,
    output logic [HAMLE_W-1:0] X22,
    output logic [HAMLE_W-1:0] X23,
    output logic [HAMLE_W-1:0] Y11,
    output logic [HAMLE_W-1:0] Y12,
    output logic [HAMLE_W-1:0] Y13,
    output logic [HAMLE_W-1:0] Y21,
    output logic [HAMLE_W-1:0] Y22,
    output logic [HAMLE_W-1:0] Y23,
    input  logic               O_in,
    output logic [1:0]         tur_no,
    output logic               karar,
    output logic               sonuc_valid,
    output logic               sonuc,
    output logic [SKOR_W-1:0]  skor_x,
    output logic [SKOR_W-1:0]  oyun_sayisi
);

    localparam logic [1:0] SON_TUR = 2'(TUR_SAYISI - 1);

    durum_t durum;
    durum_t durum_sonraki;
    logic   kabul;
    logic   son_tur;
    logic [TUR_SAYISI-1:0] yaz;

    // Ready and karar are pure decodes of the registered state, so no
    // input reaches an output combinationally.
    always_comb begin
        durum_sonraki = durum;
        hamle_ready   = 1'b0;
        karar         = 1'b0;
        case (durum)
            TOPLA: begin
                hamle_ready = 1'b1;
                if (hamle_valid && tur_no == SON_TUR) begin
                    durum_sonraki = KARAR;
                end
            end
            KARAR: begin
                karar         = 1'b1;
                durum_sonraki = TOPLA;
            end
            default: durum_sonraki = TOPLA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum <= TOPLA;
        end else begin
            durum <= durum_sonraki;
        end
    end

    assign kabul   = hamle_valid & hamle_ready;
    assign son_tur = (tur_no == SON_TUR);

    // One write enable per round, selected by the current round index.
    always_comb begin
        yaz = '0;
        for (int i = 0; i < TUR_SAYISI; i++) begin
            yaz[i] = kabul && (tur_no == 2'(i));
        end
    end

    // Round index advances on every acceptance and wraps after the last
    // round, so it already reads 0 while the game is being decided.
    always_ff @(posedge clk) begin
        if (rst) begin
            tur_no <= '0;
        end else if (kabul) begin
            tur_no <= son_tur ? 2'd0 : tur_no + 2'd1;
        end
    end

    // Result publication: the judge output is only looked at during
    // KARAR; the strobe lands in the first collect cycle afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sonuc_valid <= 1'b0;
            sonuc       <= 1'b0;
            skor_x      <= '0;
            oyun_sayisi <= '0;
        end else begin
            sonuc_valid <= (durum == KARAR);
            if (durum == KARAR) begin
                sonuc       <= O_in;
                oyun_sayisi <= oyun_sayisi + SKOR_W'(1);
                if (O_in) begin
                    skor_x <= skor_x + SKOR_W'(1);
                end
            end
        end
    end

    tur_kaydi u_tur1 (
        .clk (clk), .rst (rst), .yaz (yaz[0]),
        .x1 (x1), .x2 (x2), .y1 (y1), .y2 (y2),
        .x1_q (X11), .x2_q (X21), .y1_q (Y11), .y2_q (Y21)
    );

    tur_kaydi u_tur2 (
        .clk (clk), .rst (rst), .yaz (yaz[1]),
        .x1 (x1), .x2 (x2), .y1 (y1), .y2 (y2),
        .x1_q (X12), .x2_q (X22), .y1_q (Y12), .y2_q (Y22)
    );

    tur_kaydi u_tur3 (
        .clk (clk), .rst (rst), .yaz (yaz[2]),
        .x1 (x1), .x2 (x2), .y1 (y1), .y2 (y2),
        .x1_q (X13), .x2_q (X23), .y1_q (Y13), .y2_q (Y23)
    );

endmodule
